// File: rtl/awg_pkg.sv
`default_nettype none
// ============================================================================
// awg_pkg : shared widths, wave indices, FSM codes and helpers for the AWG
//           parameter controller.
// Revision: 1.0
// ============================================================================
package awg_pkg;

  localparam int WAVE_W  = 2;
  localparam int FREQ_W  = 12;
  localparam int AMP_W   = 8;
  localparam int PHASE_W = 8;

  localparam logic [WAVE_W-1:0] WAVE_SINE   = 2'd0;
  localparam logic [WAVE_W-1:0] WAVE_SQUARE = 2'd1;
  localparam logic [WAVE_W-1:0] WAVE_TRI    = 2'd2;
  localparam logic [WAVE_W-1:0] WAVE_SAW    = 2'd3;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_WAVE  = 3'd1,
    S_FREQ  = 3'd2,
    S_AMP   = 3'd3,
    S_PHASE = 3'd4,
    S_GAP   = 3'd5,
    S_LOAD  = 3'd6
  } state_t;

  typedef struct packed {
    logic [WAVE_W-1:0]  wave;
    logic [FREQ_W-1:0]  freq;
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] phase;
  } params_t;

  function automatic logic [3:0] wave_onehot(input logic [WAVE_W-1:0] w);
    case (w)
      WAVE_SINE:   wave_onehot = 4'b0001;
      WAVE_SQUARE: wave_onehot = 4'b0010;
      WAVE_TRI:    wave_onehot = 4'b0100;
      WAVE_SAW:    wave_onehot = 4'b1000;
      default:     wave_onehot = 4'b0000;
    endcase
  endfunction

  // The mode button cycles through the edit fields; phase wraps back to wave.
  function automatic state_t next_field(input state_t s);
    case (s)
      S_RUN:   next_field = S_WAVE;
      S_WAVE:  next_field = S_FREQ;
      S_FREQ:  next_field = S_AMP;
      S_AMP:   next_field = S_PHASE;
      S_PHASE: next_field = S_WAVE;
      default: next_field = s;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/awg_param_ctrl_if.sv
`default_nettype none
// ============================================================================
// awg_param_ctrl_if : front-panel buttons and live outputs of awg_param_ctrl.
//                     step_coarse exists only with AWG_COARSE_STEP_EN.
// Revision: 1.0
// ============================================================================
interface awg_param_ctrl_if
  import awg_pkg::*;
;
  logic                run;
  logic                btn_mode;
  logic                btn_up;
  logic                btn_down;
  logic                btn_ok;
`ifdef AWG_COARSE_STEP_EN
  logic                step_coarse;
`endif
  logic [3:0]          wave_en;
  logic [FREQ_W-1:0]   state_freq;
  logic [AMP_W-1:0]    state_amp;
  logic [PHASE_W-1:0]  state_phase;
  logic [2:0]          edit_field;
  logic                busy;

  modport master (
`ifdef AWG_COARSE_STEP_EN
    output step_coarse,
`endif
    output run, btn_mode, btn_up, btn_down, btn_ok,
    input  wave_en, state_freq, state_amp, state_phase, edit_field, busy
  );

  modport slave (
`ifdef AWG_COARSE_STEP_EN
    input  step_coarse,
`endif
    input  run, btn_mode, btn_up, btn_down, btn_ok,
    output wave_en, state_freq, state_amp, state_phase, edit_field, busy
  );

endinterface
`default_nettype wire

// File: rtl/awg_param_step.sv
`default_nettype none
// ============================================================================
// awg_param_step : combinational +/- step of one field, either wrapping
//                  modulo 2**W or saturating to [min, max].
// Revision: 1.0
// ============================================================================
module awg_param_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         dir_up,
  input  logic [W-1:0] step,
  input  logic [W-1:0] min,
  input  logic [W-1:0] max,
  input  logic         wrap,
  output logic [W-1:0] next_value
);

  logic [W:0] sum;
  logic [W:0] diff;

  // One extra bit exposes carry on the way up and borrow on the way down.
  always_comb begin
    sum  = {1'b0, value} + {1'b0, step};
    diff = {1'b0, value} - {1'b0, step};
    if (wrap) begin
      next_value = dir_up ? sum[W-1:0] : diff[W-1:0];
    end else if (dir_up) begin
      next_value = (sum > {1'b0, max}) ? max : sum[W-1:0];
    end else begin
      next_value = (diff[W] || (diff[W-1:0] < min)) ? min : diff[W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/awg_param_ctrl.sv
`default_nettype none
// ============================================================================
// awg_param_ctrl : edits a shadow copy of the AWG parameters from button
//                  pulses and applies it break-before-make on confirm.
//                  Optional macro AWG_COARSE_STEP_EN adds a x16 coarse step.
// Revision: 1.0
// ============================================================================
module awg_param_ctrl
  import awg_pkg::*;
#(
  parameter logic [FREQ_W-1:0] FREQ_MIN   = 12'd1,
  parameter logic [FREQ_W-1:0] FREQ_MAX   = 12'd4095,
  parameter logic [FREQ_W-1:0] FREQ_STEP  = 12'd1,
  parameter int                GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  awg_param_ctrl_if.slave  bus
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam params_t RESET_PARAMS = '{
    wave:  WAVE_SINE,
    freq:  FREQ_MIN,
    amp:   8'hFF,
    phase: 8'h00
  };

  state_t               state;
  state_t               state_n;
  params_t              live;
  params_t              live_n;
  params_t              shadow;
  params_t              shadow_n;
  logic [3:0]           gap_cnt;
  logic [3:0]           wave_en;
  logic [3:0]           wave_en_n;

  logic [FREQ_W-1:0]    freq_step;
  logic [AMP_W-1:0]     small_step;
  logic                 nudge;

  logic [WAVE_W-1:0]    wave_next;
  logic [FREQ_W-1:0]    freq_next;
  logic [AMP_W-1:0]     amp_next;
  logic [PHASE_W-1:0]   phase_next;

`ifdef AWG_COARSE_STEP_EN
  assign freq_step  = bus.step_coarse ? (FREQ_STEP << 4) : FREQ_STEP;
  assign small_step = bus.step_coarse ? 8'd16 : 8'd1;
`else
  assign freq_step  = FREQ_STEP;
  assign small_step = 8'd1;
`endif

  // Pressing up and down together cancels out.
  assign nudge = bus.btn_up ^ bus.btn_down;

  awg_param_step #(.W(WAVE_W)) u_step_wave (
    .value      (shadow.wave),
    .dir_up     (bus.btn_up),
    .step       (2'd1),
    .min        (2'd0),
    .max        (2'd3),
    .wrap       (1'b1),
    .next_value (wave_next)
  );

  awg_param_step #(.W(FREQ_W)) u_step_freq (
    .value      (shadow.freq),
    .dir_up     (bus.btn_up),
    .step       (freq_step),
    .min        (FREQ_MIN),
    .max        (FREQ_MAX),
    .wrap       (1'b0),
    .next_value (freq_next)
  );

  awg_param_step #(.W(AMP_W)) u_step_amp (
    .value      (shadow.amp),
    .dir_up     (bus.btn_up),
    .step       (small_step),
    .min        (8'd0),
    .max        (8'd255),
    .wrap       (1'b0),
    .next_value (amp_next)
  );

  awg_param_step #(.W(PHASE_W)) u_step_phase (
    .value      (shadow.phase),
    .dir_up     (bus.btn_up),
    .step       (small_step),
    .min        (8'd0),
    .max        (8'd255),
    .wrap       (1'b1),
    .next_value (phase_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RUN;
      live    <= RESET_PARAMS;
      shadow  <= RESET_PARAMS;
      gap_cnt <= 4'd0;
      wave_en <= 4'b0000;
    end else begin
      state   <= state_n;
      live    <= live_n;
      shadow  <= shadow_n;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
      wave_en <= wave_en_n;
    end
  end

  always_comb begin
    state_n  = state;
    live_n   = live;
    shadow_n = shadow;
    case (state)
      S_RUN: begin
        // Starting an edit always begins from what is currently playing.
        if (bus.btn_mode) begin
          state_n  = S_WAVE;
          shadow_n = live;
        end
      end
      S_WAVE, S_FREQ, S_AMP, S_PHASE: begin
        if (bus.btn_ok) begin
          state_n = S_GAP;
        end else if (bus.btn_mode) begin
          state_n = next_field(state);
        end else if (nudge) begin
          case (state)
            S_WAVE:  shadow_n.wave  = wave_next;
            S_FREQ:  shadow_n.freq  = freq_next;
            S_AMP:   shadow_n.amp   = amp_next;
            default: shadow_n.phase = phase_next;
          endcase
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        live_n  = shadow;
        state_n = S_RUN;
      end
      default: begin
        state_n = S_RUN;
      end
    endcase

    // Evaluated on the upcoming state so the register holds zero for the
    // whole apply window and the new one-hot lands on the first S_RUN cycle.
    if (bus.run && (state_n != S_GAP) && (state_n != S_LOAD)) begin
      wave_en_n = wave_onehot(live_n.wave);
    end else begin
      wave_en_n = 4'b0000;
    end
  end

  assign bus.wave_en     = wave_en;
  assign bus.state_freq  = live.freq;
  assign bus.state_amp   = live.amp;
  assign bus.state_phase = live.phase;
  assign bus.edit_field  = state;
  assign bus.busy        = (state == S_GAP) || (state == S_LOAD);

  a_wave_en_onehot0 : assert property (@(posedge clk) $onehot0(wave_en));
  a_busy_quiet      : assert property (@(posedge clk) bus.busy |-> (wave_en == 4'b0000));

endmodule
`default_nettype wire

// File: tb/tb_awg_param_ctrl.sv
`default_nettype none
// ============================================================================
// tb_awg_param_ctrl : table-driven cycle vectors plus hand-written sequences
//                     for reset-in-apply and frequency saturation.
// Revision: 1.0
// ============================================================================
module tb_awg_param_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  awg_param_ctrl_if bus();

  awg_param_ctrl #(
    .FREQ_MIN   (12'd1),
    .FREQ_MAX   (12'd4095),
    .FREQ_STEP  (12'd1),
    .GAP_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        up;
    logic        down;
    logic        ok;
    logic        run;
    logic [2:0]  field;
    logic [3:0]  en;
    logic [11:0] freq;
    logic [7:0]  amp;
    logic [7:0]  phase;
    logic        busy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic m, input logic u, input logic d, input logic o,
                     input logic r, input logic [2:0] f, input logic [3:0] en,
                     input logic [11:0] fr, input logic [7:0] a,
                     input logic [7:0] ph, input logic b);
    vec_t v;
    v.mode = m; v.up = u; v.down = d; v.ok = o; v.run = r;
    v.field = f; v.en = en; v.freq = fr; v.amp = a; v.phase = ph; v.busy = b;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic m, input logic u, input logic d,
                       input logic o, input logic r);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    bus.btn_ok   = o;
    bus.run      = r;
  endtask

  task automatic check(input string name, input logic [2:0] f,
                       input logic [3:0] en, input logic [11:0] fr,
                       input logic [7:0] a, input logic [7:0] ph,
                       input logic b);
    n_vec++;
    if (bus.edit_field !== f || bus.wave_en !== en || bus.state_freq !== fr ||
        bus.state_amp !== a || bus.state_phase !== ph || bus.busy !== b) begin
      n_bad++;
      $display("FAIL %s: got field=%0d en=%b freq=%0d amp=%0d phase=%0d busy=%b, want field=%0d en=%b freq=%0d amp=%0d phase=%0d busy=%b",
               name, bus.edit_field, bus.wave_en, bus.state_freq, bus.state_amp,
               bus.state_phase, bus.busy, f, en, fr, a, ph, b);
    end
  endtask

  // One clock with the given button pulse, buttons released afterwards.
  task automatic cycle(input logic m, input logic u, input logic d, input logic o);
    drive(m, u, d, o, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
`ifdef AWG_COARSE_STEP_EN
    bus.step_coarse = 1'b0;
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    //   m  u  d  o  r   fld en       freq   amp  ph   busy
    add(0, 0, 0, 0, 1,  0, 4'b0001, 12'd1, 255, 0,   0); // 0 out of reset
    add(1, 0, 0, 0, 1,  1, 4'b0001, 12'd1, 255, 0,   0); // 1 -> WAVE
    add(1, 0, 0, 0, 1,  2, 4'b0001, 12'd1, 255, 0,   0); // 2 -> FREQ
    add(0, 1, 0, 0, 1,  2, 4'b0001, 12'd1, 255, 0,   0); // 3 shadow 2
    add(0, 1, 0, 0, 1,  2, 4'b0001, 12'd1, 255, 0,   0); // 4 shadow 3
    add(0, 1, 0, 0, 1,  2, 4'b0001, 12'd1, 255, 0,   0); // 5 shadow 4
    add(0, 0, 0, 1, 1,  5, 4'b0000, 12'd1, 255, 0,   1); // 6 ok -> gap 1
    add(0, 0, 0, 0, 1,  5, 4'b0000, 12'd1, 255, 0,   1); // 7 gap 2
    add(0, 0, 0, 0, 1,  5, 4'b0000, 12'd1, 255, 0,   1); // 8 gap 3
    add(0, 0, 0, 0, 1,  5, 4'b0000, 12'd1, 255, 0,   1); // 9 gap 4
    add(0, 0, 0, 0, 1,  6, 4'b0000, 12'd1, 255, 0,   1); // 10 load
    add(0, 0, 0, 0, 1,  0, 4'b0001, 12'd4, 255, 0,   0); // 11 ok+6: freq 4
    add(1, 0, 0, 0, 1,  1, 4'b0001, 12'd4, 255, 0,   0); // 12 -> WAVE
    add(0, 0, 1, 0, 1,  1, 4'b0001, 12'd4, 255, 0,   0); // 13 sine-1 = saw
    add(0, 0, 0, 1, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 14 ok
    add(0, 0, 0, 0, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 15
    add(0, 0, 0, 0, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 16
    add(0, 0, 0, 0, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 17
    add(0, 0, 0, 0, 1,  6, 4'b0000, 12'd4, 255, 0,   1); // 18 load
    add(0, 0, 0, 0, 1,  0, 4'b1000, 12'd4, 255, 0,   0); // 19 saw live
    add(1, 0, 0, 0, 1,  1, 4'b1000, 12'd4, 255, 0,   0); // 20 -> WAVE
    add(1, 0, 0, 0, 1,  2, 4'b1000, 12'd4, 255, 0,   0); // 21 -> FREQ
    add(0, 0, 1, 0, 1,  2, 4'b1000, 12'd4, 255, 0,   0); // 22 shadow 3
    add(1, 0, 0, 0, 1,  3, 4'b1000, 12'd4, 255, 0,   0); // 23 -> AMP
    add(0, 1, 0, 0, 1,  3, 4'b1000, 12'd4, 255, 0,   0); // 24 255 saturates
    add(1, 0, 0, 0, 1,  4, 4'b1000, 12'd4, 255, 0,   0); // 25 -> PHASE
    add(0, 0, 1, 0, 1,  4, 4'b1000, 12'd4, 255, 0,   0); // 26 0-1 = 255
    add(0, 1, 1, 0, 1,  4, 4'b1000, 12'd4, 255, 0,   0); // 27 up+down ignored
    add(0, 0, 0, 1, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 28 ok
    add(0, 0, 0, 1, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 29 ok in gap lost
    add(1, 0, 0, 0, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 30 mode in gap lost
    add(0, 1, 0, 0, 1,  5, 4'b0000, 12'd4, 255, 0,   1); // 31 up in gap lost
    add(0, 0, 1, 0, 1,  6, 4'b0000, 12'd4, 255, 0,   1); // 32 down in gap lost
    add(1, 0, 0, 0, 1,  0, 4'b1000, 12'd3, 255, 255, 0); // 33 mode in load lost
    add(0, 0, 0, 0, 1,  0, 4'b1000, 12'd3, 255, 255, 0); // 34 not queued
    add(1, 0, 0, 0, 0,  1, 4'b0000, 12'd3, 255, 255, 0); // 35 run low
    add(1, 0, 0, 0, 0,  2, 4'b0000, 12'd3, 255, 255, 0); // 36 still editing
    add(0, 0, 0, 0, 1,  2, 4'b1000, 12'd3, 255, 255, 0); // 37 run back
    add(1, 0, 0, 0, 1,  3, 4'b1000, 12'd3, 255, 255, 0); // 38
    add(1, 0, 0, 0, 1,  4, 4'b1000, 12'd3, 255, 255, 0); // 39
    add(1, 0, 0, 0, 1,  1, 4'b1000, 12'd3, 255, 255, 0); // 40 PHASE -> WAVE

    repeat (2) @(posedge clk);
    #1;
    check("reset", 3'd0, 4'b0000, 12'd1, 8'd255, 8'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mode, tbl[i].up, tbl[i].down, tbl[i].ok, tbl[i].run);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].field, tbl[i].en, tbl[i].freq,
            tbl[i].amp, tbl[i].phase, tbl[i].busy);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset arriving in the middle of the gap.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("gap_before_rst", 3'd5, 4'b0000, 12'd3, 8'd255, 8'd255, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_gap", 3'd0, 4'b0000, 12'd1, 8'd255, 8'd0, 1'b0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    check("after_rst", 3'd0, 4'b0001, 12'd1, 8'd255, 8'd0, 1'b0);

    // Frequency lower bound.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 0, 0, 0);
    check("freq_min", 3'd0, 4'b0001, 12'd1, 8'd255, 8'd0, 1'b0);

    // Frequency upper bound: more up pulses than the range holds.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (4100) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    check("freq_max_gap", 3'd5, 4'b0000, 12'd1, 8'd255, 8'd0, 1'b1);
    repeat (5) cycle(0, 0, 0, 0);
    check("freq_max", 3'd0, 4'b0001, 12'd4095, 8'd255, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
